// File: rtl/buffer_arbiter.sv
// Round-robin arbiter sharing one delayed-write, combinational-read buffer among REQ_NUM ports.
// Define BUF_ARB_FWD_EN to forward pending-write data to a same-address read instead of stalling.
module buffer_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned REQ_NUM    = 4,
  parameter int unsigned LOCK_MAX   = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [REQ_NUM-1:0]            req,
  input  logic [REQ_NUM-1:0]            lock,
  input  logic [REQ_NUM-1:0]            req_we,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] req_addr,
  input  logic [REQ_NUM*WORD_WIDTH-1:0] req_wdata,
  output logic [REQ_NUM-1:0]            gnt,
  output logic [REQ_NUM-1:0]            rvalid,
  output logic [WORD_WIDTH-1:0]         rdata,
  output logic                          lock_timeout,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_a,
  output logic [WORD_WIDTH-1:0]         mem_d,
  input  logic [WORD_WIDTH-1:0]         mem_q
);

  localparam int unsigned PtrW = $clog2(REQ_NUM);
  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]       owner_q, owner_d;
  logic [CntW-1:0]       lock_cnt_q, lock_cnt_d;
  logic                  lock_timeout_q, lock_timeout_d;
  logic                  pend_valid_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic [REQ_NUM-1:0]    rvalid_q, rvalid_d;
  logic [WORD_WIDTH-1:0] rdata_q;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [WORD_WIDTH-1:0] mem_d_q;

  logic                  scan_valid;
  logic [PtrW-1:0]       scan_idx;
  logic                  cand_valid;
  logic [PtrW-1:0]       cand_idx;
  logic                  cand_we;
  logic [ADDR_WIDTH-1:0] cand_addr;
  logic [WORD_WIDTH-1:0] cand_wdata;
  logic                  raw_hit;
  logic                  stall;
  logic                  grant_en;
  logic [CntW:0]         cnt_inc;
  logic                  at_max;
  logic [WORD_WIDTH-1:0] read_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(REQ_NUM - 1)) return '0;
    return p + 1'b1;
  endfunction

  // First asserted request at or above rr_ptr, wrapping around.
  always_comb begin
    logic [PtrW:0] scan_pos;
    scan_valid = 1'b0;
    scan_idx   = rr_ptr_q;
    scan_pos   = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      scan_pos = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
      if (scan_pos >= (PtrW+1)'(REQ_NUM)) scan_pos = scan_pos - (PtrW+1)'(REQ_NUM);
      if (!scan_valid && req[scan_pos[PtrW-1:0]]) begin
        scan_valid = 1'b1;
        scan_idx   = scan_pos[PtrW-1:0];
      end
    end
  end

  always_comb begin
    if (state_q == StLocked) begin
      cand_valid = req[owner_q];
      cand_idx   = owner_q;
    end else begin
      cand_valid = scan_valid;
      cand_idx   = scan_idx;
    end
  end

  assign cand_we    = req_we[cand_idx];
  assign cand_addr  = req_addr[int'(cand_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign cand_wdata = req_wdata[int'(cand_idx)*WORD_WIDTH +: WORD_WIDTH];

  // The buffer commits a write one edge late, so a read right behind a write to the same
  // address would see stale contents.
  assign raw_hit = pend_valid_q && !cand_we && (cand_addr == pend_addr_q);

`ifdef BUF_ARB_FWD_EN
  logic [WORD_WIDTH-1:0] pend_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_data_q <= '0;
    end else if (grant_en && cand_we) begin
      pend_data_q <= cand_wdata;
    end
  end

  assign stall     = 1'b0;
  assign read_data = raw_hit ? pend_data_q : mem_q;
`else
  assign stall     = raw_hit;
  assign read_data = mem_q;
`endif

  assign grant_en = cand_valid && !stall && !reset;
  assign cnt_inc  = {1'b0, lock_cnt_q} + 1'b1;
  assign at_max   = cnt_inc >= (CntW+1)'(LOCK_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a stalled cycle leaves the state untouched.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_en && lock[cand_idx]) state_d = StLocked;
      end
      StLocked: begin
        if (grant_en) begin
          if (!lock[owner_q] || at_max) state_d = StIdle;
        end else if (!req[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs toward the requesters and the buffer
  always_comb begin
    gnt    = '0;
    mem_we = 1'b0;
    mem_a  = mem_a_q;
    mem_d  = mem_d_q;
    if (grant_en) begin
      gnt[cand_idx] = 1'b1;
      mem_we        = cand_we;
      mem_a         = cand_addr;
      mem_d         = cand_wdata;
    end
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    owner_d        = owner_q;
    lock_cnt_d     = lock_cnt_q;
    lock_timeout_d = lock_timeout_q;
    rvalid_d       = '0;
    if (grant_en) begin
      rr_ptr_d = ptr_inc(cand_idx);
      if (!cand_we) rvalid_d = gnt;
      if (state_q == StIdle) begin
        if (lock[cand_idx]) begin
          owner_d    = cand_idx;
          lock_cnt_d = CntW'(1);
        end
      end else begin
        lock_cnt_d = cnt_inc[CntW-1:0];
        if (lock[owner_q] && at_max) lock_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      owner_q        <= '0;
      lock_cnt_q     <= '0;
      lock_timeout_q <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_addr_q    <= '0;
      rvalid_q       <= '0;
      rdata_q        <= '0;
      mem_a_q        <= '0;
      mem_d_q        <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      owner_q        <= owner_d;
      lock_cnt_q     <= lock_cnt_d;
      lock_timeout_q <= lock_timeout_d;
      rvalid_q       <= rvalid_d;
      pend_valid_q   <= grant_en && cand_we;
      if (grant_en && cand_we) pend_addr_q <= cand_addr;
      if (grant_en && !cand_we) rdata_q <= read_data;
      if (grant_en) begin
        mem_a_q <= cand_addr;
        mem_d_q <= cand_wdata;
      end
    end
  end

  assign rvalid       = rvalid_q;
  assign rdata        = rdata_q;
  assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed bench for buffer_arbiter with a behavioural delayed-write buffer.
// LOCK_MAX is set to 12 so one instance covers both the 10-word burst and the watchdog.
module tb_buffer_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned WW = 8;
  localparam int unsigned RN = 4;
  localparam int unsigned LM = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [RN-1:0] req, lock, req_we;
  logic [RN*AW-1:0] req_addr;
  logic [RN*WW-1:0] req_wdata;
  logic [RN-1:0] gnt, rvalid;
  logic [WW-1:0] rdata, mem_d, mem_q;
  logic          lock_timeout, mem_we;
  logic [AW-1:0] mem_a;

  int n_checks = 0;
  int n_errors = 0;

  logic [WW-1:0] mem [0:(1<<AW)-1];
  logic          buf_we_q;
  logic [AW-1:0] buf_a_q;
  logic [WW-1:0] buf_d_q;

  always #5 clk = ~clk;

  buffer_arbiter #(
    .ADDR_WIDTH(AW),
    .WORD_WIDTH(WW),
    .REQ_NUM   (RN),
    .LOCK_MAX  (LM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .lock        (lock),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .lock_timeout(lock_timeout),
    .mem_we      (mem_we),
    .mem_a       (mem_a),
    .mem_d       (mem_d),
    .mem_q       (mem_q)
  );

  function automatic logic [WW-1:0] pat(input int unsigned a);
    return WW'(a * 3 + 1);
  endfunction

  // Buffer model: we/a/d registered on one edge, array written on the next.
  always @(posedge clk) begin
    if (reset) begin
      buf_we_q <= 1'b0;
      buf_a_q  <= '0;
      buf_d_q  <= '0;
      for (int i = 0; i < (1 << AW); i++) mem[i] <= pat(i);
    end else begin
      buf_we_q <= mem_we;
      buf_a_q  <= mem_a;
      buf_d_q  <= mem_d;
      if (buf_we_q) mem[buf_a_q] <= buf_d_q;
    end
  end

  assign mem_q = mem[mem_a];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int i, input logic we, input int unsigned addr,
                          input logic [WW-1:0] data);
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = AW'(addr);
    req_wdata[i*WW +: WW] = data;
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    lock      = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    tick();
    req = 4'b1111;
    #3;
    check("gnt_in_reset", gnt, 4'b0000);
    check("we_in_reset", mem_we, 1'b0);
    tick();
    reset = 1'b0;
    req   = '0;
    #3;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_rvalid", rvalid, 4'b0000);
    check("rst_rdata", rdata, 8'h00);
    check("rst_timeout", lock_timeout, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_a", mem_a, 10'd0);
    check("rst_mem_d", mem_d, 8'h00);
    tick();

    // Round-robin rotation with all four reading
    for (int i = 0; i < 4; i++) set_port(i, 1'b0, 10 + i, 8'h00);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #3;
      check("rr_gnt", gnt, 32'(1 << (k % 4)));
      check("rr_mem_a", mem_a, 32'(10 + (k % 4)));
      if (k > 0) begin
        check("rr_rvalid", rvalid, 32'(1 << ((k - 1) % 4)));
        check("rr_rdata", rdata, pat(10 + (k - 1) % 4));
      end else begin
        check("rr_rvalid0", rvalid, 4'b0000);
      end
      tick();
    end
    req = '0;
    #3;
    check("rr_last_rvalid", rvalid, 4'b0001);
    check("rr_last_rdata", rdata, pat(10));
    check("idle_gnt", gnt, 4'b0000);
    check("idle_we", mem_we, 1'b0);
    check("idle_a_hold", mem_a, 10'd10);
    tick();

    // Read-after-write to the same address (rr_ptr = 1)
    set_port(0, 1'b1, 5, 8'hA5);
    req = 4'b0001;
    #3;
    check("wr_gnt", gnt, 4'b0001);
    check("wr_we", mem_we, 1'b1);
    check("wr_a", mem_a, 10'd5);
    check("wr_d", mem_d, 8'hA5);
    tick();
    set_port(1, 1'b0, 5, 8'h00);
    req = 4'b0010;
    #3;
`ifdef BUF_ARB_FWD_EN
    check("raw_gnt_fwd", gnt, 4'b0010);
    tick();
`else
    check("raw_stall_gnt", gnt, 4'b0000);
    check("raw_stall_we", mem_we, 1'b0);
    tick();
    #3;
    check("raw_late_gnt", gnt, 4'b0010);
    tick();
`endif
    req = '0;
    #3;
    check("raw_rvalid", rvalid, 4'b0010);
    check("raw_rdata", rdata, 8'hA5);
    tick();

    // Write then read of a different address is not held back (rr_ptr = 2)
    set_port(0, 1'b1, 6, 8'h5A);
    req = 4'b0001;
    #3;
    check("nohaz_wr_gnt", gnt, 4'b0001);
    tick();
    set_port(1, 1'b0, 7, 8'h00);
    req = 4'b0010;
    #3;
    check("nohaz_rd_gnt", gnt, 4'b0010);
    tick();
    req = '0;
    #3;
    check("nohaz_rdata", rdata, pat(7));
    tick();

    // Locked 10-word burst from req2 while req0 keeps asking (rr_ptr = 2)
    set_port(0, 1'b0, 20, 8'h00);
    for (int k = 0; k < 10; k++) begin
      set_port(2, 1'b0, 100 + k, 8'h00);
      req  = 4'b0101;
      lock = (k < 9) ? 4'b0100 : 4'b0000;
      #3;
      check("burst_gnt", gnt, 4'b0100);
      if (k > 0) check("burst_rdata", rdata, pat(100 + k - 1));
      tick();
    end
    req  = 4'b0001;
    lock = '0;
    #3;
    check("burst_after_gnt", gnt, 4'b0001);
    check("burst_last_rvalid", rvalid, 4'b0100);
    check("burst_last_rdata", rdata, pat(109));
    check("burst_no_timeout", lock_timeout, 1'b0);
    tick();

    // Watchdog: req1 holds lock past LOCK_MAX while req2 waits (rr_ptr = 1)
    set_port(2, 1'b0, 30, 8'h00);
    req  = 4'b0110;
    lock = 4'b0010;
    for (int k = 0; k < LM; k++) begin
      set_port(1, 1'b0, 200 + k, 8'h00);
      #3;
      check("wdog_gnt", gnt, 4'b0010);
      check("wdog_timeout_low", lock_timeout, 1'b0);
      tick();
    end
    #3;
    check("wdog_release_gnt", gnt, 4'b0100);
    check("wdog_timeout", lock_timeout, 1'b1);
    tick();
    set_port(1, 1'b0, 250, 8'h00);
    #3;
    check("relock_gnt", gnt, 4'b0010);
    tick();

    // Reset while locked, with the relock read still returning
    reset = 1'b1;
    #3;
    check("midrst_gnt", gnt, 4'b0000);
    tick();
    reset = 1'b0;
    lock  = '0;
    for (int i = 0; i < 4; i++) set_port(i, 1'b0, 40 + i, 8'h00);
    req = 4'b1111;
    #3;
    check("postrst_rvalid", rvalid, 4'b0000);
    check("postrst_timeout", lock_timeout, 1'b0);
    check("postrst_rdata", rdata, 8'h00);
    check("postrst_gnt", gnt, 4'b0001);
    tick();
    #3;
    check("postrst_gnt2", gnt, 4'b0010);
    check("postrst_rvalid2", rvalid, 4'b0001);
    check("postrst_rdata2", rdata, pat(40));
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
